// File: rtl/train_segment_timer_if.sv
// Timer control/status bundle between the travel-time selector, the segment timer
// and the counter/synchronizer enable logic.
interface train_segment_timer_if #(
    parameter int TIME_W = 19
);
    logic              load;
    logic [TIME_W-1:0] tout;
    logic              pause;
    logic              abort;
    logic              expired;
    logic              busy;
    logic [TIME_W-1:0] remaining;
    logic [1:0]        state;

    modport master (
        output load, tout, pause, abort,
        input  expired, busy, remaining, state
    );

    modport slave (
        input  load, tout, pause, abort,
        output expired, busy, remaining, state
    );
endinterface

// File: rtl/train_segment_timer.sv
// Segment countdown timer: loads the selected travel time, counts it down in
// prescaled time units and emits a one-cycle expiry pulse at zero.
module train_segment_timer #(
    parameter int TIME_W   = 19,
    parameter int PRESCALE = 50000,
    parameter int PRESC_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    train_segment_timer_if.slave  tmr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   remaining_q, remaining_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                expired_q, expired_d;
    logic                tick;

    // Floor at zero so the count can never wrap below zero.
    function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
        return (v == '0) ? '0 : v - TIME_W'(1);
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        expired_d   = 1'b0;

        if (tmr.abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            presc_d     = '0;
        end else if (tmr.load) begin
            presc_d = '0;
            if (tmr.tout != '0) begin
                state_d     = RUN;
                remaining_d = tmr.tout;
            end else begin
                state_d     = DONE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                // Leaving HOLD counts on the same edge, so each HOLD cycle costs exactly one cycle.
                RUN, HOLD: begin
                    if (tmr.pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (tick) begin
                            presc_d     = '0;
                            remaining_d = sat_dec(remaining_q);
                            if (remaining_q == TIME_W'(1)) begin
                                state_d   = DONE;
                                expired_d = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            expired_q   <= expired_d;
        end
    end

    assign tmr.expired   = expired_q;
    assign tmr.remaining = remaining_q;
    assign tmr.state     = state_q;
    assign tmr.busy      = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_train_segment_timer.sv
// Scoreboard bench for train_segment_timer: stimulus queues expected expiry edges,
// a monitor pops them whenever the expiry pulse appears.
module tb_train_segment_timer;

    localparam int TIME_W   = 19;
    localparam int PRESCALE = 4;
    localparam int PRESC_W  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    train_segment_timer_if #(.TIME_W(TIME_W)) tmr ();

    train_segment_timer #(
        .TIME_W  (TIME_W),
        .PRESCALE(PRESCALE),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tmr  (tmr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int mon_e;

    task automatic chk(input string name, input longint act, input longint want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // At the negedge following posedge number E, cyc == E.
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drives a load for the next edge; a non-negative delay queues an expiry at t0+delay.
    task automatic do_load(input logic [TIME_W-1:0] v, input int delay, output int t0);
        tmr.load = 1'b1;
        tmr.tout = v;
        t0 = cyc + 1;
        if (delay >= 0) exp_q.push_back(t0 + delay);
        @(negedge clk);
        tmr.load = 1'b0;
    endtask

    // Monitor: every expiry pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tmr.expired) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_expired", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("expired_edge", cyc, mon_e);
                    chk("expired_state", tmr.state, 3);
                    chk("expired_remaining", tmr.remaining, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1;
        tmr.load  = 1'b0;
        tmr.tout  = '0;
        tmr.pause = 1'b0;
        tmr.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", tmr.state, 0);
        chk("rst_remaining", tmr.remaining, 0);
        chk("rst_expired", tmr.expired, 0);
        chk("rst_busy", tmr.busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic countdown, tout=3
        do_load(3, 12, t0);
        wait_cyc(t0 + 3);
        chk("run_state", tmr.state, 1);
        chk("run_remaining_3", tmr.remaining, 3);
        chk("run_busy", tmr.busy, 1);
        wait_cyc(t0 + 4);  chk("run_remaining_2", tmr.remaining, 2);
        wait_cyc(t0 + 8);  chk("run_remaining_1", tmr.remaining, 1);
        wait_cyc(t0 + 12); chk("done_state", tmr.state, 3);
        wait_cyc(t0 + 13);
        chk("after_done_state", tmr.state, 0);
        chk("after_done_expired", tmr.expired, 0);
        repeat (2) @(negedge clk);

        // Pause for edges 5..9 pushes expiry from 12 to 17
        do_load(3, 17, t0);
        wait_cyc(t0 + 4);
        tmr.pause = 1'b1;
        wait_cyc(t0 + 6);
        chk("hold_state", tmr.state, 2);
        chk("hold_remaining", tmr.remaining, 2);
        chk("hold_busy", tmr.busy, 1);
        wait_cyc(t0 + 9);
        chk("hold_state_end", tmr.state, 2);
        chk("hold_remaining_end", tmr.remaining, 2);
        tmr.pause = 1'b0;
        wait_cyc(t0 + 10); chk("resume_state", tmr.state, 1);
        wait_cyc(t0 + 18); chk("pause_final_state", tmr.state, 0);
        repeat (2) @(negedge clk);

        // tout=0 goes straight to DONE
        do_load(0, 0, t0);
        chk("zero_state", tmr.state, 3);
        chk("zero_busy", tmr.busy, 0);
        chk("zero_remaining", tmr.remaining, 0);
        @(negedge clk);
        chk("zero_after_state", tmr.state, 0);
        chk("zero_after_busy", tmr.busy, 0);
        chk("zero_after_expired", tmr.expired, 0);
        repeat (2) @(negedge clk);

        // Load accepted while in DONE
        do_load(0, 0, t0);
        do_load(2, 8, t1);
        chk("done_reload_state", tmr.state, 1);
        chk("done_reload_remaining", tmr.remaining, 2);
        wait_cyc(t1 + 9);
        repeat (2) @(negedge clk);

        // Abort mid-run, no pulse through cycle 30
        do_load(4, -1, t0);
        wait_cyc(t0 + 5);
        tmr.abort = 1'b1;
        @(negedge clk);
        tmr.abort = 1'b0;
        chk("abort_state", tmr.state, 0);
        chk("abort_remaining", tmr.remaining, 0);
        chk("abort_busy", tmr.busy, 0);
        wait_cyc(t0 + 30);
        chk("abort_late_state", tmr.state, 0);

        // Abort coinciding with load discards the load
        tmr.load  = 1'b1;
        tmr.tout  = 5;
        tmr.abort = 1'b1;
        @(negedge clk);
        tmr.load  = 1'b0;
        tmr.abort = 1'b0;
        chk("abort_load_state", tmr.state, 0);
        chk("abort_load_remaining", tmr.remaining, 0);
        repeat (2) @(negedge clk);

        // Retrigger on the final tick of tout=1
        do_load(1, -1, t0);
        wait_cyc(t0 + 3);
        do_load(2, 8, t1);
        chk("retrig_edge", t1, t0 + 4);
        chk("retrig_state", tmr.state, 1);
        chk("retrig_remaining", tmr.remaining, 2);
        chk("retrig_expired", tmr.expired, 0);
        wait_cyc(t0 + 14);

        // pause high at the load edge: load wins, HOLD the edge after
        tmr.pause = 1'b1;
        do_load(3, 13, t0);
        chk("pause_load_state", tmr.state, 1);
        chk("pause_load_remaining", tmr.remaining, 3);
        @(negedge clk);
        chk("pause_load_hold", tmr.state, 2);
        tmr.pause = 1'b0;
        wait_cyc(t0 + 15);

        // Full-scale tout loads without wrap and decrements normally
        do_load({TIME_W{1'b1}}, -1, t0);
        chk("max_remaining_load", tmr.remaining, (1 << TIME_W) - 1);
        wait_cyc(t0 + 4);
        chk("max_remaining_dec", tmr.remaining, (1 << TIME_W) - 2);
        chk("max_state", tmr.state, 1);
        tmr.abort = 1'b1;
        @(negedge clk);
        tmr.abort = 1'b0;

        // Async reset mid-run clears immediately, no pulse afterwards
        do_load(5, -1, t0);
        wait_cyc(t0 + 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", tmr.state, 0);
        chk("arst_remaining", tmr.remaining, 0);
        chk("arst_expired", tmr.expired, 0);
        chk("arst_busy", tmr.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("arst_late_state", tmr.state, 0);
        chk("arst_late_remaining", tmr.remaining, 0);

        chk("pending_expiries", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/train_segment_timer.md
Name: train_segment_timer

Overview:
- Countdown timer that consumes the travel time chosen by the selector (tout) and tells the state counter when the current track segment's time has elapsed.
- TimeMeasurement counts real sensor-to-sensor time upward. This block is the opposite end of that path: it counts a loaded time down to zero and emits a one-cycle expiry pulse.
- The expiry pulse drives the counter/sync enable logic.
- Sits between the selector (tout) and the counter/synchronizer enable logic in the top level.

Parameters:
- TIME_W, 19, width of tout and remaining (matches the selector's t1 path).
- PRESCALE, 50000, clk cycles per time unit (1 ms at 50 MHz). Must be >= 2.
- PRESC_W, 16, width of the prescaler counter. Must satisfy 2^PRESC_W >= PRESCALE.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, one-cycle request to start or restart the timer with tout.
- tout, input, TIME_W, time to count in units. Sampled only when load=1.
- pause, input, 1, level. Freezes the countdown while high.
- abort, input, 1, one-cycle cancel. Returns to IDLE with no expiry.
- expired, output, 1, registered one-cycle pulse when the count reaches 0.
- busy, output, 1, high while state is RUN or HOLD.
- remaining, output, TIME_W, registered time units left.
- state, output, 2, current state: IDLE=0, RUN=1, HOLD=2, DONE=3.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, remaining=0, prescaler=0, expired=0, busy=0.
  - Takes effect immediately, including mid-RUN. No expiry is produced.
- Priority each edge, highest first: abort, load, pause, prescaler tick.
- abort (any state):
  - Next state IDLE, remaining=0, prescaler=0, expired=0.
  - An abort coinciding with load discards the load.
- load (any state, including RUN, HOLD, DONE):
  - If tout != 0: remaining<=tout, prescaler<=0, state<=RUN. This is a retrigger; the previous count is discarded.
  - If tout == 0: state<=DONE, remaining<=0, expired<=1 on that same edge.
  - A load coinciding with the final tick wins: no expiry for the old count.
- IDLE: holds until load. Outputs are static.
- RUN:
  - Each edge, the prescaler increments.
  - When prescaler==PRESCALE-1, the prescaler wraps to 0 and remaining decrements by 1.
  - If that decrement takes remaining from 1 to 0, then state<=DONE and expired<=1 on the same edge.
- RUN with pause=1: state<=HOLD. The prescaler and remaining are frozen (no increment on that edge).
- HOLD: while pause=1, nothing changes. When pause=0, state<=RUN and counting resumes from the frozen prescaler value.
- DONE:
  - Lasts exactly one cycle. expired=1 during it.
  - Next edge: IDLE, expired<=0, unless load or abort applies.
- Latency: load sampled at edge 0 with tout=N and no pause means expired is high from edge N*PRESCALE for exactly one cycle. Each cycle spent in HOLD adds one cycle.
- busy is combinational from state.
- Arithmetic:
  - remaining never underflows; it stays 0 in IDLE and DONE.
  - tout=2^TIME_W-1 must count fully with no wrap.
- pause outside RUN/HOLD has no effect. pause=1 at the load edge: load takes priority, and HOLD is entered on the following edge.

Test Plan (PRESCALE=4):
- Reset during RUN (tout=5, rst_n low at cycle 6) -> state=0, remaining=0, expired=0 immediately. No pulse after rst_n rises.
- load with tout=3 at edge 0 -> remaining reads 2,1,0 after edges 4,8,12. expired=1 only in the cycle after edge 12. Then state=0.
- load with tout=3, pause high for 5 cycles starting at cycle 5 -> state=2 during the pause. remaining frozen at 2. expired moves to edge 17.
- load with tout=0 -> state=3 and expired=1 for one cycle after the load edge. busy never asserted.
- load with tout=4, abort at cycle 6 -> state=0, remaining=0. No expired pulse through cycle 30.
- load with tout=1, then load with tout=2 exactly at edge 4 (the final tick) -> no pulse at edge 4. expired at edge 12 only.
